// File: rtl/cardinal_pkg.sv
// Shared constants for the cardinal NIC: register map, VC tag position, data width.
package cardinal_pkg;

  localparam int NIC_DATA_WIDTH = 64;
  localparam int NIC_VC_BIT     = 63;

  localparam logic [1:0] NIC_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;

endpackage

// File: rtl/cardinal_nic_chan_buf.sv
// One-packet channel buffer: data register plus full flag; load wins over clear.
module nic_chan_buf #(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end else if (clear_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/cardinal_nic.sv
// PE <-> router NIC with one-packet input and output buffers.
// Define CARDINAL_NIC_STATS_EN to add tx_count/rx_count handshake counters.
module cardinal_nic
  import cardinal_pkg::*;
#(
  parameter int DATA_WIDTH = NIC_DATA_WIDTH,
  parameter int ADDR_WIDTH = 2,
  parameter int VC_BIT     = NIC_VC_BIT
`ifdef CARDINAL_NIC_STATS_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di
`ifdef CARDINAL_NIC_STATS_EN
  , output logic [CNT_WIDTH-1:0] tx_count,
  output logic [CNT_WIDTH-1:0] rx_count
`endif
);

  logic [DATA_WIDTH-1:0] in_buf, out_buf;
  logic                  in_full, out_full;
  logic                  pe_rd, pe_wr, out_load, in_load, in_clear;

  assign pe_rd = nicEn && !nicWrEn;
  assign pe_wr = nicEn && nicWrEn;

  // A write landing while the buffer is still full (even if it drains this cycle) is dropped.
  assign out_load = pe_wr && (addr == ADDR_WIDTH'(NIC_OUT_BUF)) && !out_full;
  assign net_so   = out_full && net_ro && (out_buf[VC_BIT] == net_polarity);
  assign net_do   = net_so ? out_buf : '0;

  assign net_ri   = !in_full;
  assign in_load  = net_si && !in_full;
  assign in_clear = pe_rd && (addr == ADDR_WIDTH'(NIC_IN_BUF)) && in_full;

  nic_chan_buf #(.WIDTH(DATA_WIDTH)) u_out_buf (
    .clk_i  (clk),
    .rst_ni (reset),
    .load_i (out_load),
    .clear_i(net_so),
    .data_i (d_in),
    .data_o (out_buf),
    .full_o (out_full)
  );

  nic_chan_buf #(.WIDTH(DATA_WIDTH)) u_in_buf (
    .clk_i  (clk),
    .rst_ni (reset),
    .load_i (in_load),
    .clear_i(in_clear),
    .data_i (net_di),
    .data_o (in_buf),
    .full_o (in_full)
  );

  always_comb begin
    d_out = '0;
    if (pe_rd) begin
      case (addr)
        ADDR_WIDTH'(NIC_IN_BUF):   d_out = in_buf;
        ADDR_WIDTH'(NIC_IN_STAT):  d_out = {{(DATA_WIDTH-1){1'b0}}, in_full};
        ADDR_WIDTH'(NIC_OUT_BUF):  d_out = out_buf;
        ADDR_WIDTH'(NIC_OUT_STAT): d_out = {{(DATA_WIDTH-1){1'b0}}, out_full};
        default:                   d_out = '0;
      endcase
    end
  end

`ifdef CARDINAL_NIC_STATS_EN
  logic [CNT_WIDTH-1:0] tx_cnt_q, rx_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (net_so)  tx_cnt_q <= tx_cnt_q + CNT_WIDTH'(1);
      if (in_load) rx_cnt_q <= rx_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign tx_count = tx_cnt_q;
  assign rx_count = rx_cnt_q;
`endif

  // The router must never strobe into a full input buffer.
  a_si_when_full : assert property (@(posedge clk) disable iff (!reset) net_si |-> !in_full);

endmodule

// File: tb/tb_cardinal_nic.sv
// Scoreboard bench for cardinal_nic: expected tx packets and read data are queued by stimulus.
module tb_cardinal_nic;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = '0;
  logic [63:0] d_in = '0;
  logic [63:0] d_out;
  logic        nicEn = 1'b0;
  logic        nicWrEn = 1'b0;
  logic        net_so;
  logic        net_ro = 1'b0;
  logic [63:0] net_do;
  logic        net_polarity = 1'b0;
  logic        net_si = 1'b0;
  logic        net_ri;
  logic [63:0] net_di = '0;
`ifdef CARDINAL_NIC_STATS_EN
  logic [15:0] tx_count, rx_count;
`endif

  int n_pass = 0;
  int n_total = 0;
  logic [63:0] exp_tx[$];
  logic [63:0] exp_rd[$];

  cardinal_nic dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_so(net_so), .net_ro(net_ro),
    .net_do(net_do), .net_polarity(net_polarity), .net_si(net_si),
    .net_ri(net_ri), .net_di(net_di)
`ifdef CARDINAL_NIC_STATS_EN
    , .tx_count(tx_count), .rx_count(rx_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // Monitor: pops expectations whenever the DUT presents a send or the PE reads.
  always @(negedge clk) begin
    if (reset) begin
      if (net_so) begin
        if (exp_tx.size() == 0) begin
          n_total++;
          $display("FAIL tx_unexpected actual=%h required=none", net_do);
        end else chk("tx_data", net_do, exp_tx.pop_front());
      end
      if (nicEn && !nicWrEn) begin
        if (exp_rd.size() == 0) begin
          n_total++;
          $display("FAIL rd_unexpected actual=%h required=none", d_out);
        end else chk("rd_data", d_out, exp_rd.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    nicEn = 1'b0; nicWrEn = 1'b0; net_si = 1'b0;
  endtask

  task automatic pe_write(input logic [1:0] a, input logic [63:0] d);
    @(posedge clk); #1;
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d; net_si = 1'b0;
  endtask

  task automatic pe_read(input logic [1:0] a, input logic [63:0] e);
    @(posedge clk); #1;
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a; net_si = 1'b0;
    exp_rd.push_back(e);
  endtask

  initial begin
    #3;
    chk("rst_so", {63'd0, net_so}, 64'd0);
    chk("rst_ri", {63'd0, net_ri}, 64'd1);
    chk("rst_dout", d_out, 64'd0);
    #20 reset = 1'b1;

    // Matching polarity: send the cycle after the write.
    net_ro = 1'b1; net_polarity = 1'b0;
    exp_tx.push_back(64'hAA);
    pe_write(2'b10, 64'hAA);
    #2 chk("pre_so", {63'd0, net_so}, 64'd0);
    step();
    #2 chk("idle_dout", d_out, 64'd0);
    pe_read(2'b11, 64'd0);
    pe_read(2'b10, 64'hAA);

    // Polarity gating.
    exp_tx.push_back(64'h8000_0000_0000_0055);
    pe_write(2'b10, 64'h8000_0000_0000_0055);
    step();
    #2 chk("gate_so", {63'd0, net_so}, 64'd0);
    step();
    pe_read(2'b11, 64'd1);
    step(); net_polarity = 1'b1;
    #2 chk("flip_so", {63'd0, net_so}, 64'd1);
    step(); net_polarity = 1'b0;
    pe_read(2'b11, 64'd0);

    // Backpressure: second write dropped, original packet eventually sent.
    net_ro = 1'b0;
    exp_tx.push_back(64'h22);
    pe_write(2'b10, 64'h22);
    step();
    pe_write(2'b10, 64'h11);
    step();
    step();
    pe_read(2'b10, 64'h22);
    pe_read(2'b11, 64'd1);
    step(); net_ro = 1'b1;
    step();
    pe_read(2'b11, 64'd0);

    // Write in the same cycle as injection is dropped.
    net_ro = 1'b0;
    exp_tx.push_back(64'h33);
    pe_write(2'b10, 64'h33);
    step();
    pe_write(2'b10, 64'h44); net_ro = 1'b1;
    step();
    pe_read(2'b11, 64'd0);
    pe_read(2'b10, 64'h33);

    // Input path.
    step(); net_si = 1'b1; net_di = 64'h1234;
    #2 chk("ri_empty", {63'd0, net_ri}, 64'd1);
    step();
    #2 chk("ri_full", {63'd0, net_ri}, 64'd0);
    pe_read(2'b01, 64'd1);
    pe_read(2'b00, 64'h1234);
    step();
    #2 chk("ri_cleared", {63'd0, net_ri}, 64'd1);
    net_si = 1'b1; net_di = 64'h5678;
    step();
    #2 chk("ri_full2", {63'd0, net_ri}, 64'd0);
    pe_read(2'b00, 64'h5678);
    pe_read(2'b01, 64'd0);
    pe_read(2'b00, 64'h5678);
    pe_read(2'b01, 64'd0);
    step();

`ifdef CARDINAL_NIC_STATS_EN
    chk("tx_count", {48'd0, tx_count}, 64'd4);
    chk("rx_count", {48'd0, rx_count}, 64'd2);
`endif

    // Reset mid-operation with both buffers full.
    net_ro = 1'b0;
    pe_write(2'b10, 64'h77);
    step(); net_si = 1'b1; net_di = 64'h99;
    step();
    @(posedge clk); #1;
    reset = 1'b0; net_ro = 1'b1;
    #1;
    chk("midrst_so", {63'd0, net_so}, 64'd0);
    chk("midrst_ri", {63'd0, net_ri}, 64'd1);
    chk("midrst_do", net_do, 64'd0);
`ifdef CARDINAL_NIC_STATS_EN
    chk("rst_tx_count", {48'd0, tx_count}, 64'd0);
`endif
    #12 reset = 1'b1;
    step();
    pe_read(2'b11, 64'd0);
    pe_read(2'b01, 64'd0);
    pe_read(2'b00, 64'd0);
    step();
    step();

    chk("tx_queue_empty", 64'(exp_tx.size()), 64'd0);
    chk("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cardinal_nic.md
Name: cardinal_nic

Overview:
- Network interface controller between one PE and its local mesh router port.
- Sits directly downstream of the PE memory-mapped NIC port and upstream of the router PE-side channel (si/ri/di and so/ro/do).
- Provides a one-packet output buffer (PE to network) and a one-packet input buffer (network to PE), each with a status flag.
- Gates output-packet injection on the router handshake and the global network polarity.

Parameters:
- DATA_WIDTH, 64, packet and PE data width.
- ADDR_WIDTH, 2, NIC register address width.
- VC_BIT, 63, packet bit that carries the virtual-channel (even/odd) tag.
- CNT_WIDTH, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset: 0 resets, 1 runs.
- addr  in  ADDR_WIDTH  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- d_in  in  DATA_WIDTH  PE write data.
- d_out  out  DATA_WIDTH  PE read data (combinational).
- nicEn  in  1  PE access enable.
- nicWrEn  in  1  1 = write, 0 = read; qualified by nicEn.
- net_so  out  1  send strobe to router.
- net_ro  in  1  router ready to accept.
- net_do  out  DATA_WIDTH  packet to router.
- net_polarity  in  1  global network polarity.
- net_si  in  1  send strobe from router.
- net_ri  out  1  NIC ready to accept from router.
- net_di  in  DATA_WIDTH  packet from router.

Behaviour:
- Reset (reset=0, asynchronous):
  - in_buf=0, in_full=0, out_buf=0, out_full=0.
  - Outputs during reset: net_so=0, net_do=0, net_ri=1, d_out=0.
  - Reset mid-packet discards both buffers; nothing is re-sent.
- PE read (nicEn=1, nicWrEn=0), d_out by addr:
  - 00: in_buf.
  - 01: {0…, in_full}.
  - 10: out_buf.
  - 11: {0…, out_full}.
  - When nicEn=0: d_out=0.
- Read side effect: a read at addr 00 with in_full=1 clears in_full at the next edge. A read at 00 with in_full=0 returns stale data and has no side effect.
- PE write (nicEn=1, nicWrEn=1):
  - addr 10 with out_full=0: out_buf<=d_in, out_full<=1 at the edge.
  - addr 10 with out_full=1: write dropped, buffer unchanged.
  - Writes to 00/01/11: ignored.
- Injection:
  - net_so=1 combinationally when out_full && net_ro && (out_buf[VC_BIT] == net_polarity); net_do=out_buf whenever net_so=1, else 0.
  - On that edge out_full<=0. A PE write to 10 in the same cycle is dropped, because out_full was still 1.
- Ejection:
  - net_ri = ~in_full (combinational).
  - net_si && net_ri: in_buf<=net_di, in_full<=1 at the edge.
  - net_si while in_full=1 is a router protocol violation: in_buf is held; an assertion fires in simulation.
- Simultaneous events:
  - PE read-clear at 00 and net_si cannot coincide, since net_ri=0 while full.
  - The next packet is accepted no earlier than the cycle after the clear.
- Latency:
  - PE write to first possible net_so: 1 cycle.
  - net_si to in_full visible at addr 01: 1 cycle.
- Wrong polarity: out_full holds and net_so=0 until polarity flips. Maximum wait is 1 cycle with an alternating polarity.

Optional Feature:
- Macro: CARDINAL_NIC_STATS_EN.
- When defined:
  - Adds outputs tx_count and rx_count, each CNT_WIDTH.
  - tx_count increments on each net_so handshake; rx_count increments on each accepted net_si.
  - Both wrap from all-ones to 0 and reset to 0.
- When undefined: ports absent, no counter logic; core behaviour is identical.

Decomposition:
- Shared package cardinal_pkg:
  - Register address constants NIC_IN_BUF=2'b00, NIC_IN_STAT=2'b01, NIC_OUT_BUF=2'b10, NIC_OUT_STAT=2'b11.
  - VC_BIT.
  - DATA_WIDTH default.
- Sub-module nic_chan_buf: one-entry register plus full flag, with load/clear controls. Instantiated twice (input and output channels).

Test Plan:
- Reset: drive reset=0 mid-operation with out_full=1 -> immediately net_so=0, net_ri=1; status reads return 0 after release.
- Output, matching polarity: write 0x0000_0000_0000_00AA to addr 10 with net_polarity=0, net_ro=1 -> net_so=1 and net_do=0x…AA the next cycle; addr 11 reads 0 afterwards.
- Output, polarity gating: write 0x8000_0000_0000_0055 with net_polarity=0 -> net_so=0; polarity flips to 1 -> net_so=1 that cycle.
- Output backpressure: out_full=1, net_ro=0 for 5 cycles, PE writes 0x11 to addr 10 -> write dropped; later injection sends the original packet.
- Input path: net_si=1, net_di=0x1234 -> net_ri=0 next cycle, addr 01 reads 1, addr 00 reads 0x1234; after the read, net_ri=1 and a second packet 0x5678 is accepted.
- Stats (macro on): 3 injections and 2 ejections -> tx_count=3, rx_count=2; preload to 16'hFFFF plus one event -> 0.
